// File: rtl/int_div_seq.sv
`default_nettype none
// ============================================================================
//  Module   : int_div_seq
//  Purpose  : Multi-cycle restoring integer divider covering DIV, DIVU, REM
//             and REMU, retiring STEP quotient bits per cycle. Divide-by-zero
//             and signed overflow are resolved in the accept cycle.
//  Revision : 1.0 - initial release
// ============================================================================
module int_div_seq #(
   parameter int XLEN = 32,   // multiple of STEP, >= 4
   parameter int STEP = 1     // 1, 2 or 4
) (
   input  logic            i_clk,
   input  logic            i_rst,
   input  logic            i_valid,
   input  logic [1:0]      i_op,
   input  logic [XLEN-1:0] i_a,
   input  logic [XLEN-1:0] i_b,
   output logic            o_busy,
   output logic            o_valid,
   output logic [XLEN-1:0] o_result
);

   localparam int c_iters = XLEN / STEP;
   localparam int c_cnt_w = (c_iters > 1) ? $clog2(c_iters) : 1;
   localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(c_iters - 1);
   localparam logic [XLEN-1:0]    c_min  = {1'b1, {(XLEN-1){1'b0}}};

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_FIX  = 2'd2
   } state_t;

   state_t            state_q,   state_d;
   logic [c_cnt_w-1:0] count_q,  count_d;
   logic [XLEN-1:0]   rem_q,     rem_d;      // partial remainder
   logic [XLEN-1:0]   quo_q,     quo_d;      // dividend shifting out, quotient shifting in
   logic [XLEN-1:0]   div_q,     div_d;      // divisor magnitude
   logic              rem_sel_q, rem_sel_d;  // 1: REM/REMU result
   logic              neg_quo_q, neg_quo_d;
   logic              neg_rem_q, neg_rem_d;
   logic [XLEN-1:0]   result_q,  result_d;
   logic              valid_q,   valid_d;

   logic              w_signed;
   logic              w_a_neg;
   logic              w_b_neg;
   logic [XLEN-1:0]   w_abs_a;
   logic [XLEN-1:0]   w_abs_b;
   logic [XLEN-1:0]   w_sel;
   logic              w_neg;
   logic [XLEN:0]     w_trial;
   logic [XLEN-1:0]   w_iter_rem;
   logic [XLEN-1:0]   w_iter_quo;
   logic              w_ge;

   // Operand sign decode and magnitude conversion (most-negative maps to 2^(XLEN-1))
   always_comb begin
      w_signed = ~i_op[0];
      w_a_neg  = w_signed & i_a[XLEN-1];
      w_b_neg  = w_signed & i_b[XLEN-1];
      w_abs_a  = w_a_neg ? (~i_a + 1'b1) : i_a;
      w_abs_b  = w_b_neg ? (~i_b + 1'b1) : i_b;
   end

   // STEP restoring iterations: shift in a dividend bit, subtract when it fits
   always_comb begin
      w_iter_rem = rem_q;
      w_iter_quo = quo_q;
      w_trial    = '0;
      w_ge       = 1'b0;
      for (int i = 0; i < STEP; i++) begin
         w_trial = {w_iter_rem, w_iter_quo[XLEN-1]};
         w_ge    = (w_trial >= {1'b0, div_q});
         if (w_ge) begin
            w_trial = w_trial - {1'b0, div_q};
         end
         w_iter_rem = w_trial[XLEN-1:0];
         w_iter_quo = {w_iter_quo[XLEN-2:0], w_ge};
      end
   end

   // Next-state, datapath and output decode
   always_comb begin
      state_d   = state_q;
      count_d   = count_q;
      rem_d     = rem_q;
      quo_d     = quo_q;
      div_d     = div_q;
      rem_sel_d = rem_sel_q;
      neg_quo_d = neg_quo_q;
      neg_rem_d = neg_rem_q;
      result_d  = result_q;
      valid_d   = 1'b0;
      w_sel     = rem_sel_q ? rem_q : quo_q;
      w_neg     = rem_sel_q ? neg_rem_q : neg_quo_q;

      case (state_q)
         S_IDLE: begin
            if (i_valid) begin
               rem_sel_d = i_op[1];
               if (i_b == '0) begin
                  result_d = i_op[1] ? i_a : '1;
                  valid_d  = 1'b1;
               end else if (w_signed && (i_a == c_min) && (i_b == '1)) begin
                  result_d = i_op[1] ? '0 : i_a;
                  valid_d  = 1'b1;
               end else begin
                  state_d   = S_CALC;
                  count_d   = '0;
                  rem_d     = '0;
                  quo_d     = w_abs_a;
                  div_d     = w_abs_b;
                  neg_quo_d = w_a_neg ^ w_b_neg;
                  neg_rem_d = w_a_neg;
               end
            end
         end
         S_CALC: begin
            rem_d   = w_iter_rem;
            quo_d   = w_iter_quo;
            count_d = count_q + c_cnt_w'(1);
            if (count_q == c_last) begin
               state_d = S_FIX;
            end
         end
         S_FIX: begin
            result_d = w_neg ? (~w_sel + 1'b1) : w_sel;
            valid_d  = 1'b1;
            state_d  = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State and datapath registers with synchronous reset
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q   <= S_IDLE;
         count_q   <= '0;
         rem_q     <= '0;
         quo_q     <= '0;
         div_q     <= '0;
         rem_sel_q <= 1'b0;
         neg_quo_q <= 1'b0;
         neg_rem_q <= 1'b0;
         result_q  <= '0;
         valid_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         count_q   <= count_d;
         rem_q     <= rem_d;
         quo_q     <= quo_d;
         div_q     <= div_d;
         rem_sel_q <= rem_sel_d;
         neg_quo_q <= neg_quo_d;
         neg_rem_q <= neg_rem_d;
         result_q  <= result_d;
         valid_q   <= valid_d;
      end
   end

   assign o_busy   = (state_q != S_IDLE);
   assign o_valid  = valid_q;
   assign o_result = result_q;

endmodule
`default_nettype wire

// File: tb/tb_int_div_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_int_div_seq
//  Purpose  : Directed checks of int_div_seq (XLEN=32, STEP=1 and STEP=4)
//  Revision : 1.0 - initial release
// ============================================================================
module tb_int_div_seq;

   logic        clk;
   logic        rst;
   logic        v1, v4;
   logic [1:0]  op_s;
   logic [31:0] a_s, b_s;
   logic        busy1, ov1, busy4, ov4;
   logic [31:0] r1, r4;

   int n_checks = 0;
   int n_fail   = 0;

   localparam logic [1:0] OP_DIV = 2'b00, OP_DIVU = 2'b01, OP_REM = 2'b10, OP_REMU = 2'b11;

   int_div_seq #(.XLEN(32), .STEP(1)) dut1 (
      .i_clk(clk), .i_rst(rst), .i_valid(v1), .i_op(op_s), .i_a(a_s), .i_b(b_s),
      .o_busy(busy1), .o_valid(ov1), .o_result(r1)
   );

   int_div_seq #(.XLEN(32), .STEP(4)) dut4 (
      .i_clk(clk), .i_rst(rst), .i_valid(v4), .i_op(op_s), .i_a(a_s), .i_b(b_s),
      .o_busy(busy4), .o_valid(ov4), .o_result(r4)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Reference model: RISC-V M-extension division semantics
   function automatic logic [31:0] ref_div(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      logic [31:0] q, r;
      if (b == 32'd0) begin
         q = 32'hFFFF_FFFF; r = a;
      end else if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
         q = a; r = 32'd0;
      end else if (!op[0]) begin
         q = $signed(a) / $signed(b);
         r = $signed(a) % $signed(b);
      end else begin
         q = a / b; r = a % b;
      end
      return op[1] ? r : q;
   endfunction

   // Issue one request and wait (bounded) for its result
   task automatic run(input bit sel, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                      output logic [31:0] res, output int lat, output int busy_cyc);
      @(negedge clk);
      op_s = op; a_s = a; b_s = b;
      if (sel) v4 = 1'b1; else v1 = 1'b1;
      @(posedge clk); #1;
      v1 = 1'b0; v4 = 1'b0;
      lat = 1; busy_cyc = 0;
      while (1) begin
         if (sel ? busy4 : busy1) busy_cyc++;
         if (sel ? ov4 : ov1) break;
         if (lat >= 200) break;
         @(posedge clk); #1;
         lat++;
      end
      res = sel ? r4 : r1;
   endtask

   task automatic vec(input string tag, input bit sel, input logic [1:0] op, input logic [31:0] a,
                      input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
      logic [31:0] res;
      int lat, bc;
      run(sel, op, a, b, res, lat, bc);
      check_eq({tag, " result"}, res, exp);
      check_eq({tag, " latency"}, lat, exp_lat);
   endtask

   initial begin
      logic [31:0] res, ra, rb, sa, sb;
      logic [1:0]  rop;
      int lat, bc, pulses;

      rst = 1'b1; v1 = 1'b0; v4 = 1'b0; op_s = '0; a_s = '0; b_s = '0;
      repeat (3) @(posedge clk);
      #1;
      check_eq("reset busy", busy1, 1'b0);
      check_eq("reset valid", ov1, 1'b0);
      check_eq("reset result", r1, 32'd0);
      rst = 1'b0;

      // Normal path, STEP=1
      run(1'b0, OP_DIV, 32'hFFFF_FFF9, 32'd2, res, lat, bc);
      check_eq("div -7/2", res, 32'hFFFF_FFFD);
      check_eq("div -7/2 latency", lat, 34);
      vec("rem -7/2", 1'b0, OP_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 34);
      run(1'b0, OP_DIVU, 32'hFFFF_FFFF, 32'h10, res, lat, bc);
      check_eq("divu ffffffff/16", res, 32'h0FFF_FFFF);
      check_eq("divu busy cycles", bc, 33);
      vec("remu ffffffff/16", 1'b0, OP_REMU, 32'hFFFF_FFFF, 32'h10, 32'hF, 34);
      vec("div 7/-2", 1'b0, OP_DIV, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 34);
      vec("rem 7/-2", 1'b0, OP_REM, 32'd7, 32'hFFFF_FFFE, 32'd1, 34);
      vec("remu 100/7", 1'b0, OP_REMU, 32'd100, 32'd7, 32'd2, 34);
      vec("div min/2", 1'b0, OP_DIV, 32'h8000_0000, 32'd2, 32'hC000_0000, 34);
      vec("div min/1", 1'b0, OP_DIV, 32'h8000_0000, 32'd1, 32'h8000_0000, 34);

      // Fast path: divide by zero and signed overflow
      run(1'b0, OP_DIV, 32'd5, 32'd0, res, lat, bc);
      check_eq("div 5/0", res, 32'hFFFF_FFFF);
      check_eq("div 5/0 latency", lat, 1);
      check_eq("div 5/0 no calc", bc, 0);
      vec("rem 5/0", 1'b0, OP_REM, 32'd5, 32'd0, 32'd5, 1);
      vec("divu 9/0", 1'b0, OP_DIVU, 32'd9, 32'd0, 32'hFFFF_FFFF, 1);
      vec("div min/-1", 1'b0, OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
      vec("rem min/-1", 1'b0, OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1);
      vec("divu min/-1", 1'b0, OP_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 34);

      // Back-to-back: second request held through busy, taken in the o_valid cycle
      @(negedge clk);
      op_s = OP_DIVU; a_s = 32'd1000; b_s = 32'd7; v1 = 1'b1;
      @(posedge clk); #1;
      op_s = OP_REM; a_s = 32'hFFFF_FF9C; b_s = 32'd7;   // -100 rem 7 = -2
      lat = 1;
      while (!ov1 && lat < 200) begin
         @(posedge clk); #1;
         lat++;
      end
      check_eq("b2b first result", r1, 32'd142);
      check_eq("b2b first latency", lat, 34);
      check_eq("b2b busy low at valid", busy1, 1'b0);
      @(posedge clk); #1;
      v1 = 1'b0;
      lat = 1;
      while (!ov1 && lat < 200) begin
         @(posedge clk); #1;
         lat++;
      end
      check_eq("b2b second result", r1, 32'hFFFF_FFFE);
      check_eq("b2b second latency", lat, 34);

      // Reset during CALC at count=10
      @(negedge clk);
      op_s = OP_DIV; a_s = 32'd12345; b_s = 32'd3; v1 = 1'b1;
      @(posedge clk); #1;
      v1 = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check_eq("abort busy", busy1, 1'b0);
      check_eq("abort result", r1, 32'd0);
      pulses = 0;
      for (int i = 0; i < 40; i++) begin
         if (ov1) pulses++;
         @(posedge clk); #1;
      end
      check_eq("abort no valid", pulses, 0);

      // Reset and request in the same cycle: request dropped
      rst = 1'b1; v1 = 1'b1; op_s = OP_DIVU; a_s = 32'd50; b_s = 32'd5;
      @(posedge clk); #1;
      rst = 1'b0; v1 = 1'b0;
      pulses = 0;
      for (int i = 0; i < 40; i++) begin
         if (ov1 || busy1) pulses++;
         @(posedge clk); #1;
      end
      check_eq("rst wins over valid", pulses, 0);

      // STEP=4 instance
      vec("s4 div -7/2", 1'b1, OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 10);
      vec("s4 remu ffffffff/16", 1'b1, OP_REMU, 32'hFFFF_FFFF, 32'h10, 32'hF, 10);
      vec("s4 div 5/0", 1'b1, OP_DIV, 32'd5, 32'd0, 32'hFFFF_FFFF, 1);
      for (int i = 0; i < 16; i++) begin
         ra  = $urandom;
         rb  = $urandom >> $urandom_range(0, 30);
         if (rb == 32'd0) rb = 32'd3;
         rop = 2'($urandom_range(0, 3));
         sa = ra; sb = rb;
         run(1'b1, rop, sa, sb, res, lat, bc);
         check_eq($sformatf("s4 rand%0d op%0d %h/%h", i, rop, sa, sb), res, ref_div(rop, sa, sb));
         check_eq($sformatf("s4 rand%0d latency", i), lat, 10);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   // Global watchdog
   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire
